// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60Hz raster constants shared by the VGA timing generator.
// Sync windows are kept here so renderers can reuse the same numbers.
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int H_VIEW  = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VIEW  = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VIEW + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VIEW + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int FRAMES_PER_SEC = 60;

  // A counter for a single state still needs one bit to exist.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter with a terminal flag; used for the line, frame
// and seconds stages, each stage's inc being the previous at_max && inc.
module wrap_counter #(
  parameter int MAX = 799,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign at_max = (count_reg == MAX_VAL);
  assign count  = count_reg;

  always_comb begin
    count_next = count_reg;
    if (inc) begin
      count_next = at_max ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: beam position, sync, blanking and a once-per-second
// tick, all decoded combinationally from three chained wrap counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VIEW_P         = H_VIEW,
  parameter int   H_FRONT_P        = H_FRONT,
  parameter int   H_SYNC_P         = H_SYNC,
  parameter int   H_BACK_P         = H_BACK,
  parameter int   V_VIEW_P         = V_VIEW,
  parameter int   V_FRONT_P        = V_FRONT,
  parameter int   V_SYNC_P         = V_SYNC,
  parameter int   V_BACK_P         = V_BACK,
  parameter logic SYNC_ACTIVE      = 1'b0,
  parameter int   FRAMES_PER_SEC_P = FRAMES_PER_SEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             hmax,
  output logic             vmax,
  output logic             hblank,
  output logic             vblank,
  output logic             visible,
  output logic             frame_end,
  output logic             sec_tick
);

  localparam int H_TOT   = H_VIEW_P + H_FRONT_P + H_SYNC_P + H_BACK_P;
  localparam int V_TOT   = V_VIEW_P + V_FRONT_P + V_SYNC_P + V_BACK_P;
  localparam int FRAME_W = cnt_width(FRAMES_PER_SEC_P);

  localparam logic [POS_W-1:0] H_VIEW_V  = POS_W'(H_VIEW_P);
  localparam logic [POS_W-1:0] V_VIEW_V  = POS_W'(V_VIEW_P);
  localparam logic [POS_W-1:0] HS_START  = POS_W'(H_VIEW_P + H_FRONT_P);
  localparam logic [POS_W-1:0] HS_END    = POS_W'(H_VIEW_P + H_FRONT_P + H_SYNC_P);
  localparam logic [POS_W-1:0] VS_START  = POS_W'(V_VIEW_P + V_FRONT_P);
  localparam logic [POS_W-1:0] VS_END    = POS_W'(V_VIEW_P + V_FRONT_P + V_SYNC_P);

  if (H_TOT > (1 << POS_W)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d does not fit in %0d bits", H_TOT, POS_W);
  end
  if (V_TOT > (1 << POS_W)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d does not fit in %0d bits", V_TOT, POS_W);
  end
  if (FRAMES_PER_SEC_P < 1) begin : g_bad_fps
    $error("vga_timing_gen: FRAMES_PER_SEC must be at least 1");
  end

  logic               v_inc;
  logic               f_inc;
  logic               f_max;
  logic [FRAME_W-1:0] frame_cnt;

  assign v_inc = ena && hmax;
  assign f_inc = v_inc && vmax;

  wrap_counter #(.MAX(H_TOT - 1), .W(POS_W)) u_h_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (ena),
    .count  (hpos),
    .at_max (hmax)
  );

  wrap_counter #(.MAX(V_TOT - 1), .W(POS_W)) u_v_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (v_inc),
    .count  (vpos),
    .at_max (vmax)
  );

  wrap_counter #(.MAX(FRAMES_PER_SEC_P - 1), .W(FRAME_W)) u_f_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (f_inc),
    .count  (frame_cnt),
    .at_max (f_max)
  );

  assign hblank    = (hpos >= H_VIEW_V);
  assign vblank    = (vpos >= V_VIEW_V);
  assign visible   = !hblank && !vblank;
  assign frame_end = hmax && vmax;
  // Not gated by ena: a tick held while paused is the same tick, not a new one.
  assign sec_tick  = frame_end && f_max;

  assign hsync = ((hpos >= HS_START) && (hpos < HS_END)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
  assign vsync = ((vpos >= VS_START) && (vpos < VS_END)) ? SYNC_ACTIVE : !SYNC_ACTIVE;

  logic unused_frame_cnt;
  assign unused_frame_cnt = ^frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor
// pops and compares them against default and small-raster instances.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, ena_a, rst_b, ena_b;

  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos, c_hpos, c_vpos;
  logic a_hsync, a_vsync, a_hmax, a_vmax, a_hblank, a_vblank, a_visible, a_frame_end, a_sec_tick;
  logic b_hsync, b_vsync, b_hmax, b_vmax, b_hblank, b_vblank, b_visible, b_frame_end, b_sec_tick;
  logic c_hsync, c_vsync, c_hmax, c_vmax, c_hblank, c_vblank, c_visible, c_frame_end, c_sec_tick;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .ena(ena_a),
    .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hsync), .vsync(a_vsync),
    .hmax(a_hmax), .vmax(a_vmax), .hblank(a_hblank), .vblank(a_vblank),
    .visible(a_visible), .frame_end(a_frame_end), .sec_tick(a_sec_tick)
  );

  vga_timing_gen #(
    .H_VIEW_P(4), .H_FRONT_P(1), .H_SYNC_P(2), .H_BACK_P(1),
    .V_VIEW_P(3), .V_FRONT_P(1), .V_SYNC_P(1), .V_BACK_P(1),
    .SYNC_ACTIVE(1'b0), .FRAMES_PER_SEC_P(3)
  ) dut_b (
    .clk(clk), .reset(rst_b), .ena(ena_b),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
    .hmax(b_hmax), .vmax(b_vmax), .hblank(b_hblank), .vblank(b_vblank),
    .visible(b_visible), .frame_end(b_frame_end), .sec_tick(b_sec_tick)
  );

  vga_timing_gen #(
    .H_VIEW_P(4), .H_FRONT_P(1), .H_SYNC_P(2), .H_BACK_P(1),
    .V_VIEW_P(3), .V_FRONT_P(1), .V_SYNC_P(1), .V_BACK_P(1),
    .SYNC_ACTIVE(1'b0), .FRAMES_PER_SEC_P(1)
  ) dut_c (
    .clk(clk), .reset(rst_b), .ena(ena_b),
    .hpos(c_hpos), .vpos(c_vpos), .hsync(c_hsync), .vsync(c_vsync),
    .hmax(c_hmax), .vmax(c_vmax), .hblank(c_hblank), .vblank(c_vblank),
    .visible(c_visible), .frame_end(c_frame_end), .sec_tick(c_sec_tick)
  );

  localparam int A_HPOS = 0, A_VPOS = 1, A_HSYNC = 2, A_VSYNC = 3, A_HMAX = 4;
  localparam int A_HBLANK = 5, A_VISIBLE = 6, A_SEC = 7;
  localparam int B_HPOS = 8, B_VPOS = 9, B_VSYNC = 10, B_VBLANK = 11;
  localparam int B_FRAME_END = 12, B_SEC = 13, C_SEC = 14;

  typedef struct {
    string name;
    int    sig;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] get_actual(input int sig);
    case (sig)
      A_HPOS:      return {22'b0, a_hpos};
      A_VPOS:      return {22'b0, a_vpos};
      A_HSYNC:     return {31'b0, a_hsync};
      A_VSYNC:     return {31'b0, a_vsync};
      A_HMAX:      return {31'b0, a_hmax};
      A_HBLANK:    return {31'b0, a_hblank};
      A_VISIBLE:   return {31'b0, a_visible};
      A_SEC:       return {31'b0, a_sec_tick};
      B_HPOS:      return {22'b0, b_hpos};
      B_VPOS:      return {22'b0, b_vpos};
      B_VSYNC:     return {31'b0, b_vsync};
      B_VBLANK:    return {31'b0, b_vblank};
      B_FRAME_END: return {31'b0, b_frame_end};
      B_SEC:       return {31'b0, b_sec_tick};
      C_SEC:       return {31'b0, c_sec_tick};
      default:     return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_val(input string name, input int sig, input int exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = get_actual(e.sig);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.exp, $time);
      end else begin
        $display("ok   %s = %0d at %0t", e.name, act, $time);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_a = 1'b1; ena_a = 1'b1;
    rst_b = 1'b1; ena_b = 1'b1;
    fork
      begin : proc_a
        tick(1);
        expect_val("a_rst_hpos", A_HPOS, 0);
        expect_val("a_rst_vpos", A_VPOS, 0);
        expect_val("a_rst_visible", A_VISIBLE, 1);
        expect_val("a_rst_hsync", A_HSYNC, 1);
        expect_val("a_rst_vsync", A_VSYNC, 1);
        expect_val("a_rst_sec", A_SEC, 0);
        tick(2);
        rst_a = 1'b0;
        expect_val("a_rel_hpos", A_HPOS, 0);
        expect_val("a_rel_visible", A_VISIBLE, 1);
        expect_val("a_rel_hsync", A_HSYNC, 1);
        tick(5);
        expect_val("a_hpos_5", A_HPOS, 5);
        tick(634);
        expect_val("a_hpos_639", A_HPOS, 639);
        expect_val("a_visible_639", A_VISIBLE, 1);
        expect_val("a_hblank_639", A_HBLANK, 0);
        tick(1);
        expect_val("a_hblank_640", A_HBLANK, 1);
        expect_val("a_visible_640", A_VISIBLE, 0);
        for (int h = 641; h <= 799; h++) begin
          tick(1);
          expect_val($sformatf("a_hsync_h%0d", h), A_HSYNC, (h >= 656 && h <= 751) ? 0 : 1);
        end
        expect_val("a_hpos_799", A_HPOS, 799);
        expect_val("a_hmax_799", A_HMAX, 1);
        tick(1);
        expect_val("a_wrap_hpos", A_HPOS, 0);
        expect_val("a_wrap_vpos", A_VPOS, 1);
        expect_val("a_wrap_hmax", A_HMAX, 0);
        tick(100);
        expect_val("a_hpos_100", A_HPOS, 100);
        ena_a = 1'b0;
        tick(10);
        expect_val("a_hold_hpos", A_HPOS, 100);
        expect_val("a_hold_vpos", A_VPOS, 1);
        expect_val("a_hold_hsync", A_HSYNC, 1);
        expect_val("a_hold_visible", A_VISIBLE, 1);
        ena_a = 1'b1;
        tick(1);
        expect_val("a_resume_hpos", A_HPOS, 101);
        checks++;
        if (a_hpos !== 10'd101) begin
            errors++;
            $display("FAIL a_resume_direct: got %0d expected 101 at %0t", a_hpos, $time);
        end else begin
            $display("ok   a_resume_direct = %0d at %0t", a_hpos, $time);
        end
      end
      begin : proc_b
        tick(3);
        rst_b = 1'b0;
        expect_val("b_rel_hpos", B_HPOS, 0);
        expect_val("b_rel_sec", B_SEC, 0);
        for (int k = 1; k <= 499; k++) begin
          int f;
          tick(1);
          f = k % 48;
          expect_val($sformatf("b_sec_k%0d", k), B_SEC, (k == 143 || k == 287 || k == 431) ? 1 : 0);
          expect_val($sformatf("c_sec_k%0d", k), C_SEC, (f == 47) ? 1 : 0);
          expect_val($sformatf("b_vblank_k%0d", k), B_VBLANK, (f >= 24) ? 1 : 0);
          expect_val($sformatf("b_vsync_k%0d", k), B_VSYNC, (f >= 32 && f < 40) ? 0 : 1);
          expect_val($sformatf("b_fend_k%0d", k), B_FRAME_END, (f == 47) ? 1 : 0);
          if (k == 47) begin
            expect_val("b_last_hpos", B_HPOS, 7);
            expect_val("b_last_vpos", B_VPOS, 5);
          end
          if (k == 48) begin
            expect_val("b_wrap_hpos", B_HPOS, 0);
            expect_val("b_wrap_vpos", B_VPOS, 0);
          end
        end
        expect_val("b_mid_hpos", B_HPOS, 3);
        expect_val("b_mid_vpos", B_VPOS, 2);
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
        expect_val("b_rst_hpos", B_HPOS, 0);
        expect_val("b_rst_vpos", B_VPOS, 0);
        expect_val("b_rst_sec", B_SEC, 0);
        checks++;
        if (b_hpos !== 10'd0 || b_vpos !== 10'd0 || b_sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL b_rst_direct: got (%0d,%0d,%0d) expected (0,0,0) at %0t",
                     b_hpos, b_vpos, b_sec_tick, $time);
        end else begin
            $display("ok   b_rst_direct = (%0d,%0d,%0d) at %0t", b_hpos, b_vpos, b_sec_tick, $time);
        end
        for (int j = 1; j <= 150; j++) begin
          tick(1);
          expect_val($sformatf("b_sec_after_rst_j%0d", j), B_SEC, (j == 143) ? 1 : 0);
          expect_val($sformatf("c_sec_after_rst_j%0d", j), C_SEC, (j % 48 == 47) ? 1 : 0);
        end
      end
    join
    @(negedge clk);
    #1;
    if (errors != 0) begin
        $display("FAIL scoreboard_mismatches: got %0d expected 0", errors);
    end else begin
        $display("ok   scoreboard_mismatches = %0d", errors);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
